// File: rtl/sequential_reader.sv
// -----------------------------------------------------------------------------
// sequential_reader
//
// Reads `count` consecutive 64-bit records from global memory over an AXI4
// read channel, starting at byte address `offset`, and replays them in order
// on a 64-bit AXI4-Stream source. Bursts are split so none crosses a 4 KB
// page, and a burst is only requested once the record buffer can absorb all
// of its beats. This lets RREADY stay high for the whole burst.
//
// Ports
//   clk, rst          kernel clock, synchronous active-high reset
//   start             one-cycle job request, taken only while idle=1
//   offset, count     job byte base address (8-byte aligned) and record count
//   idle, done, error job status: idle level, completion pulse, sticky error
//   axiAR*            read address channel (master)
//   axiR*             read data channel (master)
//   outT*             record stream (source); TLAST marks the job's last record
// -----------------------------------------------------------------------------
module sequential_reader #(
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] offset,
  input  logic [31:0] count,
  output logic        idle,
  output logic        done,
  output logic        error,
  output logic        axiARVALID,
  input  logic        axiARREADY,
  output logic [63:0] axiARADDR,
  output logic [7:0]  axiARLEN,
  output logic [2:0]  axiARSIZE,
  input  logic        axiRVALID,
  output logic        axiRREADY,
  input  logic [63:0] axiRDATA,
  input  logic [1:0]  axiRRESP,
  input  logic        axiRLAST,
  output logic [63:0] outTDATA,
  output logic        outTVALID,
  input  logic        outTREADY,
  output logic        outTLAST
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [31:0] MAX_BURST_U  = 32'(MAX_BURST);
  localparam logic [31:0] FIFO_DEPTH_U = 32'(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DRAIN} state_t;

  // Control state
  state_t      state_reg;
  logic [63:0] addr_reg;          // next burst address
  logic [31:0] remaining_reg;     // records not yet requested
  logic [31:0] stream_left_reg;   // records not yet handed out on the stream
  logic [AW:0] reserved_reg;      // buffer entries promised to the open burst
  logic [8:0]  burst_len_reg;     // beats in the current burst (1..256)
  logic [8:0]  beat_cnt_reg;      // beats received in the current burst
  logic        idle_reg;
  logic        done_reg;
  logic        error_reg;
  logic        arvalid_reg;
  logic [63:0] araddr_reg;
  logic [7:0]  arlen_reg;
  logic        rready_reg;

  // Record buffer: RAM body plus a head register that drives the stream.
  logic [63:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   ram_cnt_reg;     // entries held in the RAM body
  logic          out_valid_reg;   // head register occupied
  logic [63:0]   out_data_reg;

  // Handshakes and buffer moves
  logic r_fire;
  logic t_fire;
  logic out_free;
  logic ram_to_out;
  logic bypass;
  logic ram_wr;

  // Burst sizing
  logic [12:0] page_room;
  logic [31:0] page_beats;
  logic [31:0] burst_beats;
  logic [31:0] fifo_used;
  logic [31:0] fifo_free;
  logic        space_ok;
  logic        last_beat;

  assign r_fire   = axiRVALID && rready_reg;
  assign t_fire   = out_valid_reg && outTREADY;
  assign out_free = !out_valid_reg || t_fire;

  // The head register refills from the RAM first; an incoming beat only
  // skips the RAM when nothing older is waiting, which keeps order intact
  // and gives one cycle from R beat to TVALID.
  assign ram_to_out = out_free && (ram_cnt_reg != '0);
  assign bypass     = out_free && (ram_cnt_reg == '0) && r_fire;
  assign ram_wr     = r_fire && !bypass;

  assign last_beat  = (beat_cnt_reg == burst_len_reg - 9'd1);

  always_comb begin
    page_room   = 13'd4096 - {1'b0, addr_reg[11:0]};
    page_beats  = 32'(page_room >> 3);
    burst_beats = remaining_reg;
    if (burst_beats > MAX_BURST_U) begin
      burst_beats = MAX_BURST_U;
    end
    if (burst_beats > page_beats) begin
      burst_beats = page_beats;
    end
    // Free space counts both stored records and beats still owed to us.
    fifo_used = 32'(ram_cnt_reg) + 32'(out_valid_reg) + 32'(reserved_reg);
    fifo_free = FIFO_DEPTH_U - fifo_used;
    space_ok  = (fifo_free >= burst_beats);
  end

  // ---------------------------------------------------------------------------
  // Job control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      addr_reg        <= '0;
      remaining_reg   <= '0;
      stream_left_reg <= '0;
      reserved_reg    <= '0;
      burst_len_reg   <= '0;
      beat_cnt_reg    <= '0;
      idle_reg        <= 1'b1;
      done_reg        <= 1'b0;
      error_reg       <= 1'b0;
      arvalid_reg     <= 1'b0;
      araddr_reg      <= '0;
      arlen_reg       <= '0;
      rready_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;

      if (t_fire) begin
        stream_left_reg <= stream_left_reg - 32'd1;
      end

      if (r_fire && (axiRRESP != 2'b00)) begin
        error_reg <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (start) begin
            error_reg <= 1'b0;
            if (count == 32'd0) begin
              done_reg <= 1'b1;
            end else begin
              addr_reg        <= offset;
              remaining_reg   <= count;
              stream_left_reg <= count;
              idle_reg        <= 1'b0;
              state_reg       <= ADDR;
            end
          end
        end

        ADDR: begin
          if (!arvalid_reg) begin
            // Length is frozen here so ARADDR/ARLEN stay stable until ARREADY.
            if (space_ok) begin
              arvalid_reg   <= 1'b1;
              araddr_reg    <= addr_reg;
              arlen_reg     <= 8'(burst_beats - 32'd1);
              burst_len_reg <= 9'(burst_beats);
            end
          end else if (axiARREADY) begin
            arvalid_reg   <= 1'b0;
            reserved_reg  <= reserved_reg + burst_len_reg[AW:0];
            addr_reg      <= addr_reg + {52'd0, burst_len_reg, 3'b000};
            remaining_reg <= remaining_reg - {23'd0, burst_len_reg};
            beat_cnt_reg  <= '0;
            rready_reg    <= 1'b1;
            state_reg     <= DATA;
          end
        end

        DATA: begin
          if (r_fire) begin
            reserved_reg <= reserved_reg - CNT_ONE;
            beat_cnt_reg <= beat_cnt_reg + 9'd1;
            // Our own beat count ends the burst; RLAST is only cross-checked.
            if (last_beat != axiRLAST) begin
              error_reg <= 1'b1;
            end
            if (last_beat) begin
              rready_reg <= 1'b0;
              state_reg  <= (remaining_reg == 32'd0) ? DRAIN : ADDR;
            end
          end
        end

        DRAIN: begin
          if (t_fire && (stream_left_reg == 32'd1)) begin
            done_reg  <= 1'b1;
            idle_reg  <= 1'b1;
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Record buffer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      mem[wr_ptr_reg] <= axiRDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      ram_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (ram_to_out) begin
        out_data_reg  <= mem[rd_ptr_reg];
        rd_ptr_reg    <= rd_ptr_reg + PTR_ONE;
        out_valid_reg <= 1'b1;
      end else if (bypass) begin
        out_data_reg  <= axiRDATA;
        out_valid_reg <= 1'b1;
      end else if (t_fire) begin
        out_valid_reg <= 1'b0;
      end

      if (ram_wr) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end

      case ({ram_wr, ram_to_out})
        2'b10:   ram_cnt_reg <= ram_cnt_reg + CNT_ONE;
        2'b01:   ram_cnt_reg <= ram_cnt_reg - CNT_ONE;
        default: ram_cnt_reg <= ram_cnt_reg;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign idle       = idle_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign axiARVALID = arvalid_reg;
  assign axiARADDR  = araddr_reg;
  assign axiARLEN   = arlen_reg;
  assign axiARSIZE  = 3'b011;
  assign axiRREADY  = rready_reg;
  assign outTDATA   = out_data_reg;
  assign outTVALID  = out_valid_reg;
  // stream_left only moves on a pop, so TLAST is stable while stalled.
  assign outTLAST   = out_valid_reg && (stream_left_reg == 32'd1);

endmodule
